// File: rtl/ro_puf_eval_ctrl.sv
// Ring-oscillator PUF challenge evaluator: for each oscillator pair it settles, counts
// rising edges of both oscillators over a window, and compares the counts to form one response bit.
module ro_puf_eval_ctrl #(
  parameter int N_RO   = 16,
  parameter int SEL_W  = 4,
  parameter int RESP_W = 4,
  parameter int CNT_W  = 16,
  parameter int WIN_W  = 16,
  parameter int SETTLE = 8,
  parameter int CHAL_W = RESP_W * 2 * SEL_W
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESET,
  input  logic              start,
  input  logic              abort,
  input  logic [CHAL_W-1:0] challenge,
  input  logic [WIN_W-1:0]  window_len,
  input  logic              ro_a_sync,
  input  logic              ro_b_sync,
  output logic              ro_en,
  output logic [SEL_W-1:0]  sel_a,
  output logic [SEL_W-1:0]  sel_b,
  output logic              busy,
  output logic              done,
  output logic              resp_valid,
  output logic [RESP_W-1:0] response,
  output logic [RESP_W-1:0] tie_mask,
  output logic [CNT_W-1:0]  last_cnt_a,
  output logic [CNT_W-1:0]  last_cnt_b
);

  localparam int KW   = (RESP_W > 1) ? $clog2(RESP_W) : 1;
  localparam int ST_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  if (N_RO > (1 << SEL_W)) begin : g_bad_n_ro
    $error("N_RO does not fit in SEL_W select bits");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_COUNT,
    ST_COMPARE,
    ST_DONE
  } state_t;

  state_t            state;
  logic [CHAL_W-1:0] chal_q;
  logic [WIN_W-1:0]  win_q;
  logic [WIN_W-1:0]  win_cnt;
  logic [ST_W-1:0]   settle_cnt;
  logic [KW-1:0]     k;
  logic [CNT_W-1:0]  cnt_a;
  logic [CNT_W-1:0]  cnt_b;
  logic              ro_a_prev;
  logic              ro_b_prev;

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state      <= ST_IDLE;
      chal_q     <= '0;
      win_q      <= '0;
      win_cnt    <= '0;
      settle_cnt <= '0;
      k          <= '0;
      cnt_a      <= '0;
      cnt_b      <= '0;
      ro_a_prev  <= 1'b0;
      ro_b_prev  <= 1'b0;
      ro_en      <= 1'b0;
      sel_a      <= '0;
      sel_b      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      resp_valid <= 1'b0;
      response   <= '0;
      tie_mask   <= '0;
      last_cnt_a <= '0;
      last_cnt_b <= '0;
    end else begin
      // Edge history tracks every cycle so the first COUNT cycle never sees a false edge
      ro_a_prev <= ro_a_sync;
      ro_b_prev <= ro_b_sync;
      done      <= 1'b0;
      if (abort) begin
        state      <= ST_IDLE;
        ro_en      <= 1'b0;
        busy       <= 1'b0;
        resp_valid <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && window_len != '0) begin
              chal_q     <= challenge;
              win_q      <= window_len;
              k          <= '0;
              resp_valid <= 1'b0;
              response   <= '0;
              tie_mask   <= '0;
              sel_a      <= challenge[0 +: SEL_W];
              sel_b      <= challenge[SEL_W +: SEL_W];
              ro_en      <= 1'b1;
              busy       <= 1'b1;
              settle_cnt <= '0;
              state      <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            cnt_a <= '0;
            cnt_b <= '0;
            if (settle_cnt == ST_W'(SETTLE - 1)) begin
              win_cnt <= '0;
              state   <= ST_COUNT;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          ST_COUNT: begin
            if (ro_a_sync && !ro_a_prev && cnt_a != '1) cnt_a <= cnt_a + 1'b1;
            if (ro_b_sync && !ro_b_prev && cnt_b != '1) cnt_b <= cnt_b + 1'b1;
            if (win_cnt == win_q - 1'b1) state <= ST_COMPARE;
            else win_cnt <= win_cnt + 1'b1;
          end
          ST_COMPARE: begin
            response[k] <= (cnt_a > cnt_b);
            tie_mask[k] <= (cnt_a == cnt_b);
            last_cnt_a  <= cnt_a;
            last_cnt_b  <= cnt_b;
            if (k == KW'(RESP_W - 1)) begin
              busy       <= 1'b0;
              ro_en      <= 1'b0;
              done       <= 1'b1;
              resp_valid <= 1'b1;
              state      <= ST_DONE;
            end else begin
              k          <= k + 1'b1;
              sel_a      <= chal_q[(int'(k) + 1) * 2 * SEL_W +: SEL_W];
              sel_b      <= chal_q[(int'(k) + 1) * 2 * SEL_W + SEL_W +: SEL_W];
              settle_cnt <= '0;
              state      <= ST_SETTLE;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ro_puf_eval_ctrl.sv
// Directed bench for ro_puf_eval_ctrl: a default instance plus a 4-bit-counter instance
// for saturation, both fed the same stimulus.
module tb_ro_puf_eval_ctrl;

  localparam int SEL_W  = 4;
  localparam int RESP_W = 4;
  localparam int WIN_W  = 16;
  localparam int SETTLE = 8;
  localparam int CHAL_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              start;
  logic              abort;
  logic [CHAL_W-1:0] challenge;
  logic [WIN_W-1:0]  window_len;
  logic              ro_a;
  logic              ro_b;

  logic              ro_en, busy, done, resp_valid;
  logic [SEL_W-1:0]  sel_a, sel_b;
  logic [RESP_W-1:0] response, tie_mask;
  logic [15:0]       last_cnt_a, last_cnt_b;

  logic              sat_ro_en, sat_busy, sat_done, sat_resp_valid;
  logic [SEL_W-1:0]  sat_sel_a, sat_sel_b;
  logic [RESP_W-1:0] sat_response, sat_tie_mask;
  logic [3:0]        sat_last_cnt_a, sat_last_cnt_b;

  ro_puf_eval_ctrl dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .start(start), .abort(abort),
    .challenge(challenge), .window_len(window_len), .ro_a_sync(ro_a), .ro_b_sync(ro_b),
    .ro_en(ro_en), .sel_a(sel_a), .sel_b(sel_b), .busy(busy), .done(done),
    .resp_valid(resp_valid), .response(response), .tie_mask(tie_mask),
    .last_cnt_a(last_cnt_a), .last_cnt_b(last_cnt_b)
  );

  ro_puf_eval_ctrl #(.CNT_W(4)) dut_sat (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .start(start), .abort(abort),
    .challenge(challenge), .window_len(window_len), .ro_a_sync(ro_a), .ro_b_sync(ro_b),
    .ro_en(sat_ro_en), .sel_a(sat_sel_a), .sel_b(sat_sel_b), .busy(sat_busy), .done(sat_done),
    .resp_valid(sat_resp_valid), .response(sat_response), .tie_mask(sat_tie_mask),
    .last_cnt_a(sat_last_cnt_a), .last_cnt_b(sat_last_cnt_b)
  );

  int total = 0;
  int bad   = 0;

  // Square-wave oscillator models; a period of 0 holds the line low
  int period_a = 0;
  int period_b = 0;
  int phase    = 0;
  initial begin
    ro_a = 1'b0;
    ro_b = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      phase++;
      ro_a = (period_a != 0) && ((phase % period_a) < (period_a / 2));
      ro_b = (period_b != 0) && ((phase % period_b) < (period_b / 2));
    end
  end

  int         lat;
  logic [3:0] seen_a[4];
  logic [3:0] seen_b[4];
  logic       busy1, roen1, busy_at_done, rv_at_done;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts an evaluation and waits for done; optionally pulses a second start at cycle late_n
  task automatic run_eval(input logic [31:0] chal, input logic [15:0] win, input int late_n,
                          input logic [31:0] chal2, input logic [15:0] win2);
    int p;
    p = SETTLE + int'(win) + 1;
    lat = 0;
    busy_at_done = 1'bx;
    rv_at_done = 1'bx;
    challenge = chal;
    window_len = win;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 3000; n++) begin
      if (n == 1) begin
        busy1 = busy;
        roen1 = ro_en;
      end
      for (int j = 0; j < 4; j++) begin
        if (n == 1 + j * p) begin
          seen_a[j] = sel_a;
          seen_b[j] = sel_b;
        end
      end
      if (done) begin
        lat = n;
        busy_at_done = busy;
        rv_at_done = resp_valid;
        break;
      end
      if (n == late_n) begin
        challenge = chal2;
        window_len = win2;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({ro_en, busy, done, resp_valid} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL reset_flags: got %b expected 0000", {ro_en, busy, done, resp_valid});
    end
    total++;
    if ({sel_a, sel_b, response, tie_mask} !== 16'h0) begin
      bad++;
      $display("[TB] FAIL reset_sel_resp: got %h expected 0000", {sel_a, sel_b, response, tie_mask});
    end
    total++;
    if ({last_cnt_a, last_cnt_b} !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_counts: got %h expected 00000000", {last_cnt_a, last_cnt_b});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_nominal();
    period_a = 4;
    period_b = 8;
    run_eval(32'h76543210, 16'd100, 0, 32'h0, 16'd0);
    total++;
    if (lat != 437) begin
      bad++;
      $display("[TB] FAIL nominal_latency: got %0d expected 437", lat);
    end
    total++;
    if (busy1 !== 1'b1 || roen1 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL nominal_first_cycle: busy=%b ro_en=%b expected 1 1", busy1, roen1);
    end
    total++;
    if (busy_at_done !== 1'b0 || rv_at_done !== 1'b1) begin
      bad++;
      $display("[TB] FAIL nominal_done_cycle: busy=%b resp_valid=%b expected 0 1", busy_at_done, rv_at_done);
    end
    total++;
    if (response !== 4'b1111 || tie_mask !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL nominal_response: got resp=%b tie=%b expected 1111 0000", response, tie_mask);
    end
    total++;
    if (last_cnt_a < 24 || last_cnt_a > 26) begin
      bad++;
      $display("[TB] FAIL nominal_cnt_a: got %0d expected 24..26", last_cnt_a);
    end
    total++;
    if (last_cnt_b < 12 || last_cnt_b > 13) begin
      bad++;
      $display("[TB] FAIL nominal_cnt_b: got %0d expected 12..13", last_cnt_b);
    end
    tick();
    total++;
    if (done !== 1'b0 || resp_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL nominal_after_done: done=%b resp_valid=%b expected 0 1", done, resp_valid);
    end
  endtask

  task automatic test_tie_select();
    period_a = 6;
    period_b = 6;
    run_eval(32'h76543210, 16'd20, 0, 32'h0, 16'd0);
    total++;
    if (lat != 117) begin
      bad++;
      $display("[TB] FAIL tie_latency: got %0d expected 117", lat);
    end
    total++;
    if (response !== 4'b0000 || tie_mask !== 4'b1111) begin
      bad++;
      $display("[TB] FAIL tie_response: got resp=%b tie=%b expected 0000 1111", response, tie_mask);
    end
    for (int j = 0; j < 4; j++) begin
      total++;
      if (seen_a[j] !== 4'(2 * j) || seen_b[j] !== 4'(2 * j + 1)) begin
        bad++;
        $display("[TB] FAIL tie_sel_pair%0d: got (%0d,%0d) expected (%0d,%0d)",
                 j, seen_a[j], seen_b[j], 2 * j, 2 * j + 1);
      end
    end
    tick();
  endtask

  task automatic test_saturation();
    period_a = 2;
    period_b = 0;
    run_eval(32'h76543210, 16'd100, 0, 32'h0, 16'd0);
    total++;
    if (lat != 437) begin
      bad++;
      $display("[TB] FAIL sat_latency: got %0d expected 437", lat);
    end
    total++;
    if (sat_last_cnt_a !== 4'd15 || sat_last_cnt_b !== 4'd0) begin
      bad++;
      $display("[TB] FAIL sat_counts: got a=%0d b=%0d expected a=15 b=0", sat_last_cnt_a, sat_last_cnt_b);
    end
    total++;
    if (sat_response !== 4'b1111 || sat_resp_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL sat_response: got resp=%b valid=%b expected 1111 1", sat_response, sat_resp_valid);
    end
    total++;
    if (last_cnt_a !== 16'd50 || last_cnt_b !== 16'd0) begin
      bad++;
      $display("[TB] FAIL wide_counts: got a=%0d b=%0d expected a=50 b=0", last_cnt_a, last_cnt_b);
    end
    tick();
  endtask

  task automatic test_ignored_start();
    logic saw_busy, saw_done;
    period_a = 4;
    period_b = 8;
    run_eval(32'h76543210, 16'd100, 50, 32'hFEDCBA98, 16'd5);
    total++;
    if (lat != 437) begin
      bad++;
      $display("[TB] FAIL busy_start_latency: got %0d expected 437", lat);
    end
    total++;
    if (seen_a[3] !== 4'd6 || seen_b[3] !== 4'd7 || seen_a[2] !== 4'd4 || seen_b[2] !== 4'd5) begin
      bad++;
      $display("[TB] FAIL busy_start_sel: got p2=(%0d,%0d) p3=(%0d,%0d) expected (4,5) (6,7)",
               seen_a[2], seen_b[2], seen_a[3], seen_b[3]);
    end
    total++;
    if (response !== 4'b1111) begin
      bad++;
      $display("[TB] FAIL busy_start_response: got %b expected 1111", response);
    end
    tick();
    challenge = 32'h76543210;
    window_len = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    saw_busy = 1'b0;
    saw_done = 1'b0;
    for (int n = 0; n < 20; n++) begin
      saw_busy |= busy;
      saw_done |= done;
      tick();
    end
    total++;
    if (saw_busy !== 1'b0 || saw_done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL zero_window: busy_seen=%b done_seen=%b expected 0 0", saw_busy, saw_done);
    end
  endtask

  task automatic test_abort();
    logic saw_done;
    period_a = 4;
    period_b = 8;
    saw_done = 1'b0;
    challenge = 32'h76543210;
    window_len = 16'd20;
    start = 1'b1;
    tick();
    start = 1'b0;
    // Pair 2 counts over cycles 67..86 after start; abort lands mid-window
    for (int n = 1; n < 70; n++) begin
      saw_done |= done;
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if ({busy, ro_en, resp_valid, done} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL abort_idle: got busy/ro_en/valid/done=%b expected 0000",
               {busy, ro_en, resp_valid, done});
    end
    total++;
    if (response !== 4'b0011 || tie_mask !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL abort_partial: got resp=%b tie=%b expected 0011 0000", response, tie_mask);
    end
    for (int n = 0; n < 150; n++) begin
      saw_done |= done;
      tick();
    end
    total++;
    if (saw_done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL abort_no_done: got done_seen=%b expected 0", saw_done);
    end
    run_eval(32'h76543210, 16'd20, 0, 32'h0, 16'd0);
    total++;
    if (lat != 117 || response !== 4'b1111) begin
      bad++;
      $display("[TB] FAIL abort_restart: got lat=%0d resp=%b expected 117 1111", lat, response);
    end
    tick();
  endtask

  task automatic test_reset_mid_settle();
    challenge = 32'h76543254;
    window_len = 16'd20;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    total++;
    if (sel_a !== 4'd4 || sel_b !== 4'd5 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL settle_before_reset: got sel=(%0d,%0d) busy=%b expected (4,5) 1",
               sel_a, sel_b, busy);
    end
    rst = 1'b1;
    tick();
    total++;
    if ({ro_en, busy, done, resp_valid, sel_a, sel_b, response, tie_mask} !== 20'h0) begin
      bad++;
      $display("[TB] FAIL reset_mid_settle: got %h expected 00000",
               {ro_en, busy, done, resp_valid, sel_a, sel_b, response, tie_mask});
    end
    total++;
    if ({last_cnt_a, last_cnt_b} !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_mid_settle_counts: got %h expected 00000000", {last_cnt_a, last_cnt_b});
    end
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    challenge = '0;
    window_len = '0;
    test_reset();
    test_nominal();
    test_tie_select();
    test_saturation();
    test_ignored_start();
    test_abort();
    test_reset_mid_settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
